// File: rtl/cfg_dispatch.sv
// Configuration command dispatcher: edge-captures 32-bit RBCP words into a 4-deep FIFO,
// then executes them one at a time as local register accesses or 24-bit mode-0 SPI writes.
module cfg_dispatch #(
  parameter logic [4:0] BOARD_ID = 5'd2,
  parameter int         CLK_DIV  = 4
) (
  input  logic         sitcp_user_clk,
  input  logic         rst_n,
  input  logic         cfg_32_valid,
  input  logic [31:0]  cfg_32_data,
  input  logic [31:0]  cfg_32_addr,
  output logic [255:0] reg_bank,
  output logic [15:0]  rd_data,
  output logic         rd_valid,
  output logic         spi_sclk,
  output logic         spi_mosi,
  output logic         spi_cs_n,
  output logic         busy,
  output logic [7:0]   drop_cnt,
  output logic         ovf,
  output logic [2:0]   dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE, S_DECODE, S_LOCAL, S_SPI_LOAD, S_SPI_SHIFT, S_SPI_END
  } state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  state_t       r_state, w_next;
  logic         r_valid_d;
  logic [31:0]  r_fifo [4];
  logic [1:0]   r_wr_ptr, r_rd_ptr;
  logic [2:0]   r_count;
  logic [31:0]  r_cmd;
  logic [15:0]  r_regs [16];
  logic [23:0]  r_shift;
  logic [7:0]   r_div;
  logic [5:0]   r_edges;
  logic         r_sclk, r_cs_n, r_ovf, r_rd_valid;
  logic [15:0]  r_rd_data;
  logic [7:0]   r_drop;

  logic w_push, w_pop, w_push_ok, w_ovf_drop, w_dec_drop, w_empty, w_full;
  logic w_div_done, w_board_bad;
  logic [1:0] w_drop_inc;
  logic [8:0] w_drop_sum;
  logic w_unused;

  // Upstream has no ready: a word is taken on the 0->1 transition of cfg_32_valid only.
  assign w_push      = cfg_32_valid & ~r_valid_d;
  assign w_empty     = (r_count == 3'd0);
  assign w_full      = (r_count == 3'd4);
  assign w_push_ok   = w_push & (~w_full | w_pop);
  assign w_ovf_drop  = w_push & w_full & ~w_pop;
  assign w_div_done  = (r_div == DIV_LAST);
  assign w_board_bad = (r_cmd[28:24] != BOARD_ID) && (r_cmd[28:24] != 5'd0);
  assign w_drop_inc  = {1'b0, w_ovf_drop} + {1'b0, w_dec_drop};
  assign w_drop_sum  = {1'b0, r_drop} + {7'b0, w_drop_inc};
  assign w_unused    = ^{cfg_32_addr, r_cmd[30:29]};

  always_ff @(posedge sitcp_user_clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_pop      = 1'b0;
    w_dec_drop = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop  = 1'b1;
          w_next = S_DECODE;
        end
      end
      S_DECODE: begin
        if (w_board_bad) begin
          w_dec_drop = 1'b1;
          w_next     = S_IDLE;
        end else if (r_cmd[23:20] == 4'h0) begin
          w_next = S_LOCAL;
        end else if (r_cmd[31]) begin
          w_next = S_SPI_LOAD;
        end else begin
          w_dec_drop = 1'b1;
          w_next     = S_IDLE;
        end
      end
      S_LOCAL:     w_next = S_IDLE;
      S_SPI_LOAD:  w_next = S_SPI_SHIFT;
      S_SPI_SHIFT: if (w_div_done && r_edges == 6'd47) w_next = S_SPI_END;
      S_SPI_END:   if (w_div_done) w_next = S_IDLE;
      default:     w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge sitcp_user_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid_d  <= 1'b0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_cmd      <= '0;
      for (int i = 0; i < 4; i++)  r_fifo[i] <= '0;
      for (int i = 0; i < 16; i++) r_regs[i] <= '0;
      r_shift    <= '0;
      r_div      <= '0;
      r_edges    <= '0;
      r_sclk     <= 1'b0;
      r_cs_n     <= 1'b1;
      r_ovf      <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
      r_drop     <= '0;
    end else begin
      r_valid_d  <= cfg_32_valid;
      r_rd_valid <= 1'b0;
      if (w_push_ok) begin
        r_fifo[r_wr_ptr] <= cfg_32_data;
        r_wr_ptr         <= r_wr_ptr + 2'd1;
      end
      if (w_pop) begin
        r_cmd    <= r_fifo[r_rd_ptr];
        r_rd_ptr <= r_rd_ptr + 2'd1;
      end
      r_count <= r_count + {2'b0, w_push_ok} - {2'b0, w_pop};
      if (w_ovf_drop) r_ovf <= 1'b1;
      r_drop <= w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];

      case (r_state)
        S_DECODE: begin
          // Chip select drops together with entering SPI_LOAD so the load cycle is part of the frame.
          if (w_next == S_SPI_LOAD) begin
            r_shift <= r_cmd[23:0];
            r_cs_n  <= 1'b0;
          end
        end
        S_LOCAL: begin
          if (r_cmd[31]) begin
            r_regs[r_cmd[19:16]] <= r_cmd[15:0];
          end else begin
            r_rd_data  <= r_regs[r_cmd[19:16]];
            r_rd_valid <= 1'b1;
          end
        end
        S_SPI_LOAD: begin
          r_div   <= '0;
          r_edges <= '0;
          r_sclk  <= 1'b0;
        end
        S_SPI_SHIFT: begin
          if (w_div_done) begin
            r_div   <= '0;
            r_sclk  <= ~r_sclk;
            r_edges <= r_edges + 6'd1;
            if (r_sclk) r_shift <= {r_shift[22:0], 1'b0};
          end else begin
            r_div <= r_div + 8'd1;
          end
        end
        S_SPI_END: begin
          if (w_div_done) begin
            r_div  <= '0;
            r_cs_n <= 1'b1;
          end else begin
            r_div <= r_div + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    reg_bank = '0;
    for (int i = 0; i < 16; i++) reg_bank[16*i +: 16] = r_regs[i];
  end

  assign rd_data   = r_rd_data;
  assign rd_valid  = r_rd_valid;
  assign spi_sclk  = r_sclk;
  assign spi_mosi  = r_shift[23];
  assign spi_cs_n  = r_cs_n;
  assign busy      = (r_state != S_IDLE) || !w_empty;
  assign drop_cnt  = r_drop;
  assign ovf       = r_ovf;
  assign dbg_state = r_state;

endmodule

// File: doc/cfg_dispatch.md
CFG_DISPATCH -- requirements
Module: cfg_dispatch

Interface
REQ-001 Parameter BOARD_ID, default 5'd2, is the board address this block answers to; address 5'd0 is global and is always accepted.
REQ-002 Parameter CLK_DIV, default 4, is the number of sitcp_user_clk cycles per SPI clock half-period; legal range 1-255.
REQ-003 Port sitcp_user_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 Port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 Port cfg_32_valid, input, 1 bit: upstream command strobe; may stay high for 1-2 cycles.
REQ-006 Port cfg_32_data, input, 32 bits: command word with fields wr=[31], board=[28:24], comp=[23:16], data=[15:0].
REQ-007 Port cfg_32_addr, input, 32 bits: RBCP address; it is ignored and kept only for interface compatibility.
REQ-008 Port reg_bank, output, 256 bits: the 16 local 16-bit registers, with register n at bits [16n+15:16n].
REQ-009 Port rd_data, output, 16 bits: read-back value.
REQ-010 Port rd_valid, output, 1 bit: one-cycle pulse that qualifies rd_data.
REQ-011 Port spi_sclk, output, 1 bit: SPI clock, mode 0, idles low.
REQ-012 Port spi_mosi, output, 1 bit: SPI serial data out.
REQ-013 Port spi_cs_n, output, 1 bit: SPI chip select, active low.
REQ-014 Port busy, output, 1 bit: high whenever the FSM is not in IDLE or the FIFO is not empty.
REQ-015 Port drop_cnt, output, 8 bits: count of rejected commands; saturates at 255.
REQ-016 Port ovf, output, 1 bit: sticky flag, set on FIFO overflow.

Function
REQ-017 A command is captured only on a rising edge of cfg_32_valid (previous-cycle low, current-cycle high); a valid held high yields exactly one capture.
REQ-018 Each captured word is pushed into a 4-entry FIFO.
REQ-019 Push when the FIFO is full: the word is discarded, ovf is set, and drop_cnt increments.
REQ-020 Simultaneous push and pop in the same cycle are both honoured, including when the FIFO is full.
REQ-021 The FSM has states IDLE, DECODE, LOCAL, SPI_LOAD, SPI_SHIFT and SPI_END.
REQ-022 IDLE transitions: if the FIFO is not empty, pop the head into the command register and go to DECODE.
REQ-023 DECODE, board mismatch: if board is not BOARD_ID and not 0, drop_cnt increments and the FSM returns to IDLE.
REQ-024 DECODE, local target: if comp < 8'h10, go to LOCAL.
REQ-025 DECODE, SPI target with wr=1: go to SPI_LOAD.
REQ-026 DECODE, SPI target with wr=0: the read is unsupported, drop_cnt increments and the FSM returns to IDLE.
REQ-027 LOCAL with wr=1: register[comp[3:0]] takes data, visible on reg_bank the cycle after LOCAL; return to IDLE.
REQ-028 LOCAL with wr=0: rd_data takes register[comp[3:0]] and rd_valid pulses for one cycle; return to IDLE.
REQ-029 Latency from FIFO-head availability in IDLE to the register update is 3 cycles (IDLE, DECODE, LOCAL).
REQ-030 SPI_LOAD: load a 24-bit shift register with {comp, data}, drive spi_cs_n low, drive the MSB on spi_mosi, and go to SPI_SHIFT.
REQ-031 SPI_SHIFT: toggle spi_sclk every CLK_DIV cycles; spi_mosi changes only on sclk falling edges, so data is stable at each rising edge.
REQ-032 SPI_SHIFT sends exactly 24 bits MSB-first, then the FSM goes to SPI_END with spi_sclk low.
REQ-033 SPI_END: hold spi_cs_n low for CLK_DIV cycles, then drive it high and return to IDLE.
REQ-034 A complete SPI frame with CLK_DIV=D spans 1 + 48·D + D cycles, from SPI_LOAD to spi_cs_n going high.
REQ-035 Commands are processed strictly in FIFO order, one at a time; new captures continue to fill the FIFO during SPI activity.
REQ-036 drop_cnt saturates at 8'hFF, and ovf stays set until reset.
REQ-037 Global-address writes (board 0) are handled exactly like writes addressed to BOARD_ID.

Reset
REQ-038 While rst_n is low, every register is asynchronously cleared: FSM to IDLE, FIFO empty, reg_bank=0, rd_data=0, rd_valid=0, drop_cnt=0, ovf=0.
REQ-039 While rst_n is low, SPI outputs are held at spi_sclk=0, spi_mosi=0 and spi_cs_n=1, and busy=0.
REQ-040 Reset asserted mid-SPI-frame: spi_cs_n goes high immediately, the frame is abandoned and never resumed, and queued commands are lost.
REQ-041 On rst_n release, the edge detector treats cfg_32_valid as previously low.

Verification
REQ-042 Local write then read: a valid pulse with 32'h8203_ABCD, then one with 32'h0203_0000 -> reg_bank[63:48]=16'hABCD, and rd_data=16'hABCD with a single rd_valid pulse.
REQ-043 SPI write: a valid pulse with 32'h8245_1234, CLK_DIV=4 -> a 24-bit frame 24'h451234 is captured on sclk rising edges, spi_cs_n is low for 1+192+4 cycles, and busy returns to 0.
REQ-044 Filtering: words 32'h8307_0001 (wrong board), 32'h0250_0000 (SPI read) and 32'h8007_0055 (global) -> drop_cnt=2 and reg_bank[127:112]=16'h0055.
REQ-045 Overflow: 6 valid pulses spaced 3 cycles apart, all SPI writes, during an active frame -> 4 entries queued, later frames sent in order, ovf=1, drop_cnt=1 or more per lost word, and a valid held high for 2 cycles counts as a single capture.
REQ-046 Reset mid-frame: rst_n pulsed low at bit 10 of a frame -> spi_cs_n=1 immediately, all outputs at reset values, and no further SPI activity.
